mask_centroid: RTL

//  Stream sink for the binary-mask video produced by the morphological stages (erosion/dilatation/open).

---
 rtl/mask_centroid_if.sv | 22 ++
 rtl/mask_centroid.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mask_centroid_if.sv
// Video bus between the morphology stages and the centroid sink.
// The source drives the *_in fields; the sink drives the re-emitted *_out fields.
interface mask_centroid_if;
  logic [23:0] mask_in;
  logic        de_in;
  logic        h_sync_in;
  logic        v_sync_in;
  logic [23:0] pixel_out;
  logic        de_out;
  logic        h_sync_out;
  logic        v_sync_out;

  modport master (
    output mask_in, de_in, h_sync_in, v_sync_in,
    input  pixel_out, de_out, h_sync_out, v_sync_out
  );

  modport slave (
    input  mask_in, de_in, h_sync_in, v_sync_in,
    output pixel_out, de_out, h_sync_out, v_sync_out
  );
endinterface

// File: rtl/mask_centroid.sv
// Binary-mask centroid tracker: per-frame moments, sequential division at frame end,
// and a one-cycle re-emitted stream with a red crosshair at the previous centroid.
module mask_centroid #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int ACC_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mask_centroid_if.slave    vid,
  output logic [10:0]       x_c,
  output logic [10:0]       y_c,
  output logic              c_valid,
  output logic              busy,
  output logic              empty,
  output logic              overrun,
  output logic [1:0]        state_dbg
);
  // Stream has no backpressure: every de/sync/pixel beat is consumed in its own
  // cycle, and c_valid is a one-cycle qualifier for the x_c/y_c values beside it.
  localparam int CW    = 11;
  localparam int CNT_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;

  state_t state, state_nxt;

  logic              de_q, h_q, v_q;
  logic [23:0]       pix_q;
  logic [CW-1:0]     x_cnt, y_cnt;
  logic [ACC_W-1:0]  m00, sx, sy;
  logic [ACC_W-1:0]  dvd_x, dvd_y, rem_x, rem_y, dvsr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              cent_ok;

  logic              frame_end, de_fall, fg;
  logic              div_load, div_step, div_finish, empty_hit, overrun_hit;
  logic [ACC_W:0]    shx, shy, subx, suby;
  logic              gex, gey;

  assign frame_end = vid.v_sync_in & ~v_q;
  assign de_fall   = ~vid.de_in & de_q;
  assign fg        = |vid.mask_in;

  assign vid.pixel_out  = pix_q;
  assign vid.de_out     = de_q;
  assign vid.h_sync_out = h_q;
  assign vid.v_sync_out = v_q;
  assign state_dbg      = state;

  // Pixel coordinates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (vid.de_in) begin
        if (x_cnt != CW'(IMG_W - 1)) x_cnt <= x_cnt + CW'(1);
      end else begin
        x_cnt <= '0;
      end
      if (frame_end)
        y_cnt <= '0;
      else if (de_fall && (y_cnt != CW'(IMG_H - 1)))
        y_cnt <= y_cnt + CW'(1);
    end
  end

  // Moment accumulators; a frame end always starts a fresh frame, even if the divider is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m00 <= '0;
      sx  <= '0;
      sy  <= '0;
    end else if (frame_end) begin
      m00 <= '0;
      sx  <= '0;
      sy  <= '0;
    end else if (vid.de_in && fg) begin
      m00 <= m00 + ACC_W'(1);
      sx  <= sx + ACC_W'(x_cnt);
      sy  <= sy + ACC_W'(y_cnt);
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (frame_end && (m00 != '0)) state_nxt = S_DIV;
      S_DIV:  if (bit_cnt == CNT_W'(ACC_W - 1)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy        = (state != S_IDLE);
    div_load    = (state == S_IDLE) && frame_end && (m00 != '0);
    empty_hit   = (state == S_IDLE) && frame_end && (m00 == '0);
    overrun_hit = (state != S_IDLE) && frame_end;
    div_step    = (state == S_DIV);
    div_finish  = (state == S_DONE);
  end

  // Restoring division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shx  = {rem_x, dvd_x[ACC_W-1]};
    shy  = {rem_y, dvd_y[ACC_W-1]};
    subx = shx - {1'b0, dvsr};
    suby = shy - {1'b0, dvsr};
    gex  = (shx >= {1'b0, dvsr});
    gey  = (shy >= {1'b0, dvsr});
  end

  // Two dividers sharing the divisor; the dividend registers fill with quotient bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_x   <= '0;
      dvd_y   <= '0;
      rem_x   <= '0;
      rem_y   <= '0;
      dvsr    <= '0;
      bit_cnt <= '0;
      x_c     <= '0;
      y_c     <= '0;
      cent_ok <= 1'b0;
      c_valid <= 1'b0;
      empty   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      c_valid <= div_finish;
      empty   <= empty_hit;
      overrun <= overrun_hit;
      if (div_load) begin
        dvd_x   <= sx;
        dvd_y   <= sy;
        dvsr    <= m00;
        rem_x   <= '0;
        rem_y   <= '0;
        bit_cnt <= '0;
      end else if (div_step) begin
        rem_x   <= gex ? subx[ACC_W-1:0] : shx[ACC_W-1:0];
        rem_y   <= gey ? suby[ACC_W-1:0] : shy[ACC_W-1:0];
        dvd_x   <= {dvd_x[ACC_W-2:0], gex};
        dvd_y   <= {dvd_y[ACC_W-2:0], gey};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (div_finish) begin
        x_c     <= dvd_x[10:0];
        y_c     <= dvd_y[10:0];
        cent_ok <= 1'b1;
      end
    end
  end

  // Output stream; the crosshair compares against the centroid held when the pixel enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q  <= 1'b0;
      h_q   <= 1'b0;
      v_q   <= 1'b0;
      pix_q <= '0;
    end else begin
      de_q <= vid.de_in;
      h_q  <= vid.h_sync_in;
      v_q  <= vid.v_sync_in;
      if (!vid.de_in)
        pix_q <= '0;
      else if (cent_ok && ((x_cnt == x_c) || (y_cnt == y_c)))
        pix_q <= 24'hFF0000;
      else
        pix_q <= vid.mask_in;
    end
  end
endmodule
